board_controller: RTL and testbench

Game-state sequencer for the 16x16 minesweeper grid. It holds per-cell mine/revealed/flagged state and drives the cursor position consumed by the block renderer. It executes reveal and flag commands, including an iterative flood-fill sweep for zero-adjacency cells, and declares win or loss. It sits between the button debouncers and the VGA block renderer, and serves the renderer through a registered read port.

---
 rtl/board_pkg.sv | 36 +++
 rtl/board_controller_neighbour_count.sv | 40 ++++
 rtl/board_controller.sv | 177 +++++++++++++++++
 tb/tb_board_controller.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared constants and encodings for the minesweeper board sequencer.
package board_pkg;

  localparam int unsigned GRID_W    = 16;
  localparam int unsigned GRID_H    = 16;
  localparam int unsigned CELL_AW   = 8;
  localparam int unsigned NUM_CELLS = GRID_W * GRID_H;
  localparam int unsigned XY_W      = 4;
  localparam int unsigned ADJ_W     = 4;

  localparam logic [XY_W-1:0]    XY_MAX      = XY_W'(GRID_W - 1);
  localparam logic [CELL_AW:0]   CELLS_TOTAL = (CELL_AW + 1)'(NUM_CELLS);
  localparam logic [CELL_AW:0]   CNT_ONE     = (CELL_AW + 1)'(1);

  // rd_cell field layout: {revealed, flagged, mine, adj[3:0]}
  localparam int unsigned RD_W        = 7;
  localparam int unsigned RD_REVEALED = 6;
  localparam int unsigned RD_FLAGGED  = 5;
  localparam int unsigned RD_MINE     = 4;
  localparam int unsigned RD_ADJ_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_CHECK,
    ST_LOST,
    ST_WON
  } fsm_state_e;

  typedef enum logic [1:0] {
    GS_PLAY = 2'd0,
    GS_LOST = 2'd1,
    GS_WON  = 2'd2
  } game_state_e;

endpackage

// File: rtl/board_controller_neighbour_count.sv
// Combinational 3x3-window evaluation for one cell: adjacent mine count and
// whether any neighbour is an already-revealed empty (adj==0) cell.
module neighbour_count
  import board_pkg::*;
(
  input  logic [CELL_AW-1:0]   addr,
  input  logic [NUM_CELLS-1:0] mine_map,
  input  logic [NUM_CELLS-1:0] zero_rev,
  output logic [ADJ_W-1:0]     adj,
  output logic                 zero_nbr
);

  always_comb begin : eval
    int nx;
    int ny;
    int cx;
    int cy;
    int idx;
    adj      = '0;
    zero_nbr = 1'b0;
    cx       = int'(addr) % int'(GRID_W);
    cy       = int'(addr) / int'(GRID_W);
    nx       = 0;
    ny       = 0;
    idx      = 0;
    for (int unsigned d = 0; d < 9; d++) begin
      if (d != 4) begin
        nx = cx + int'(d % 3) - 1;
        ny = cy + int'(d / 3) - 1;
        // Out-of-grid neighbours are skipped, so rows never wrap.
        if (nx >= 0 && nx < int'(GRID_W) && ny >= 0 && ny < int'(GRID_H)) begin
          idx      = ny * int'(GRID_W) + nx;
          adj      = adj + ADJ_W'(mine_map[idx[CELL_AW-1:0]]);
          zero_nbr = zero_nbr | zero_rev[idx[CELL_AW-1:0]];
        end
      end
    end
  end

endmodule

// File: rtl/board_controller.sv
// Minesweeper game-state sequencer: cursor, reveal/flag commands, flood-fill
// sweep, win/loss detection and a registered cell read port for the renderer.
module board_controller
  import board_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_reveal,
  input  logic               btn_flag,
  input  logic               new_game,
  input  logic               mine_we,
  input  logic [CELL_AW-1:0] mine_waddr,
  input  logic               mine_wdata,
  input  logic [CELL_AW-1:0] rd_addr,
  output logic [RD_W-1:0]    rd_cell,
  output logic [XY_W-1:0]    x_pos,
  output logic [XY_W-1:0]    y_pos,
  output logic               busy,
  output logic [1:0]         game_state
);

  fsm_state_e           state;
  game_state_e          gs;
  logic [NUM_CELLS-1:0] mine_map;
  logic [NUM_CELLS-1:0] revealed;
  logic [NUM_CELLS-1:0] flagged;
  logic [NUM_CELLS-1:0] zero_rev;
  logic [CELL_AW:0]     revealed_cnt;
  logic [CELL_AW:0]     mine_cnt;
  logic [CELL_AW-1:0]   sweep_idx;
  logic [CELL_AW-1:0]   cur_addr;
  logic                 changed;
  logic [ADJ_W-1:0]     cur_adj;
  logic [ADJ_W-1:0]     sw_adj;
  logic [ADJ_W-1:0]     rd_adj;
  logic                 sw_zero_nbr;
  logic                 unused_cur_zero;
  logic                 unused_rd_zero;
  logic                 sweep_hit;

  assign cur_addr   = {y_pos, x_pos};
  assign game_state = gs;
  assign sweep_hit  = !revealed[sweep_idx] && !flagged[sweep_idx] &&
                      !mine_map[sweep_idx] && sw_zero_nbr;

  // zero_rev caches "revealed with adj==0" at reveal time, so each sweep step
  // only needs the 3x3 window around the index rather than a 5x5 one.
  neighbour_count u_cur_nbr (
    .addr(cur_addr), .mine_map(mine_map), .zero_rev(zero_rev),
    .adj(cur_adj), .zero_nbr(unused_cur_zero)
  );
  neighbour_count u_sweep_nbr (
    .addr(sweep_idx), .mine_map(mine_map), .zero_rev(zero_rev),
    .adj(sw_adj), .zero_nbr(sw_zero_nbr)
  );
  neighbour_count u_rd_nbr (
    .addr(rd_addr), .mine_map(mine_map), .zero_rev(zero_rev),
    .adj(rd_adj), .zero_nbr(unused_rd_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      gs           <= GS_PLAY;
      mine_map     <= '0;
      revealed     <= '0;
      flagged      <= '0;
      zero_rev     <= '0;
      revealed_cnt <= '0;
      mine_cnt     <= '0;
      sweep_idx    <= '0;
      changed      <= 1'b0;
      x_pos        <= '0;
      y_pos        <= '0;
      rd_cell      <= '0;
      busy         <= 1'b0;
    end else begin
      rd_cell <= {revealed[rd_addr], flagged[rd_addr], mine_map[rd_addr], rd_adj};

      if (mine_we && state == ST_IDLE) begin
        mine_map[mine_waddr] <= mine_wdata;
        if (mine_wdata && !mine_map[mine_waddr]) begin
          mine_cnt <= mine_cnt + CNT_ONE;
        end else if (!mine_wdata && mine_map[mine_waddr]) begin
          mine_cnt <= mine_cnt - CNT_ONE;
        end
      end

      if (new_game) begin
        revealed     <= '0;
        flagged      <= '0;
        zero_rev     <= '0;
        revealed_cnt <= '0;
        sweep_idx    <= '0;
        changed      <= 1'b0;
        x_pos        <= '0;
        y_pos        <= '0;
        busy         <= 1'b0;
        state        <= ST_IDLE;
        gs           <= GS_PLAY;
      end else begin
        if (btn_up) begin
          if (y_pos != '0) y_pos <= y_pos - XY_W'(1);
        end else if (btn_down) begin
          if (y_pos != XY_MAX) y_pos <= y_pos + XY_W'(1);
        end else if (btn_left) begin
          if (x_pos != '0) x_pos <= x_pos - XY_W'(1);
        end else if (btn_right) begin
          if (x_pos != XY_MAX) x_pos <= x_pos + XY_W'(1);
        end

        case (state)
          ST_IDLE: begin
            if (btn_reveal) begin
              if (!flagged[cur_addr] && !revealed[cur_addr]) begin
                if (mine_map[cur_addr]) begin
                  revealed <= revealed | mine_map;
                  state    <= ST_LOST;
                  gs       <= GS_LOST;
                end else begin
                  revealed[cur_addr] <= 1'b1;
                  revealed_cnt       <= revealed_cnt + CNT_ONE;
                  if (cur_adj == '0) begin
                    zero_rev[cur_addr] <= 1'b1;
                    sweep_idx          <= '0;
                    changed            <= 1'b0;
                    busy               <= 1'b1;
                    state              <= ST_SWEEP;
                  end else begin
                    state <= ST_CHECK;
                  end
                end
              end
            end else if (btn_flag && !revealed[cur_addr]) begin
              flagged[cur_addr] <= !flagged[cur_addr];
            end
          end
          ST_SWEEP: begin
            if (sweep_hit) begin
              revealed[sweep_idx] <= 1'b1;
              zero_rev[sweep_idx] <= (sw_adj == '0);
              revealed_cnt        <= revealed_cnt + CNT_ONE;
            end
            if (sweep_idx == '1) begin
              if (changed || sweep_hit) begin
                changed   <= 1'b0;
                sweep_idx <= '0;
              end else begin
                busy  <= 1'b0;
                state <= ST_CHECK;
              end
            end else begin
              changed   <= changed | sweep_hit;
              sweep_idx <= sweep_idx + CELL_AW'(1);
            end
          end
          ST_CHECK: begin
            if (revealed_cnt == CELLS_TOTAL - mine_cnt) begin
              state <= ST_WON;
              gs    <= GS_WON;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_LOST, ST_WON: begin
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_board_controller.sv
// Randomized self-checking bench for board_controller against a flood-fill game model.
module tb_board_controller;
  import board_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_down, btn_left, btn_right, btn_reveal, btn_flag;
  logic       new_game, mine_we, mine_wdata;
  logic [7:0] mine_waddr, rd_addr;
  logic [6:0] rd_cell;
  logic [3:0] x_pos, y_pos;
  logic       busy;
  logic [1:0] game_state;

  int checks = 0;
  int errors = 0;

  bit         m_mine [256];
  bit         m_rev  [256];
  bit         m_flag [256];
  int         m_x, m_y, m_gs;
  logic [6:0] got_board [256];

  board_controller dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_reveal(btn_reveal), .btn_flag(btn_flag), .new_game(new_game),
    .mine_we(mine_we), .mine_waddr(mine_waddr), .mine_wdata(mine_wdata),
    .rd_addr(rd_addr), .rd_cell(rd_cell), .x_pos(x_pos), .y_pos(y_pos),
    .busy(busy), .game_state(game_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int m_adj(int a);
    int n = 0;
    int cx = a % 16;
    int cy = a / 16;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if ((dx != 0 || dy != 0) && cx + dx >= 0 && cx + dx < 16 && cy + dy >= 0 && cy + dy < 16)
          n += int'(m_mine[(cy + dy) * 16 + cx + dx]);
    return n;
  endfunction

  function automatic bit m_touches_open_empty(int a);
    int cx = a % 16;
    int cy = a / 16;
    int n;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if ((dx != 0 || dy != 0) && cx + dx >= 0 && cx + dx < 16 && cy + dy >= 0 && cy + dy < 16) begin
          n = (cy + dy) * 16 + cx + dx;
          if (m_rev[n] && !m_mine[n] && m_adj(n) == 0) return 1'b1;
        end
    return 1'b0;
  endfunction

  task automatic m_reveal(int a);
    bit grew;
    int safe_open, mines;
    if (m_gs != 0 || m_flag[a] || m_rev[a]) return;
    if (m_mine[a]) begin
      for (int i = 0; i < 256; i++) if (m_mine[i]) m_rev[i] = 1'b1;
      m_gs = 1;
      return;
    end
    m_rev[a] = 1'b1;
    if (m_adj(a) == 0) begin
      grew = 1'b1;
      while (grew) begin
        grew = 1'b0;
        for (int i = 0; i < 256; i++)
          if (!m_rev[i] && !m_flag[i] && !m_mine[i] && m_touches_open_empty(i)) begin
            m_rev[i] = 1'b1;
            grew = 1'b1;
          end
      end
    end
    safe_open = 0;
    mines = 0;
    for (int i = 0; i < 256; i++) begin
      if (m_rev[i] && !m_mine[i]) safe_open++;
      if (m_mine[i]) mines++;
    end
    if (safe_open == 256 - mines) m_gs = 2;
  endtask

  task automatic m_flag_op(int a);
    if (m_gs == 0 && !m_rev[a]) m_flag[a] = !m_flag[a];
  endtask

  task automatic m_move(input bit u, input bit d, input bit l, input bit r);
    if (u) begin
      if (m_y > 0) m_y--;
    end else if (d) begin
      if (m_y < 15) m_y++;
    end else if (l) begin
      if (m_x > 0) m_x--;
    end else if (r) begin
      if (m_x < 15) m_x++;
    end
  endtask

  function automatic logic [6:0] exp_cell(int a);
    return {m_rev[a], m_flag[a], m_mine[a], 4'(m_adj(a))};
  endfunction

  function automatic int board_bad(output int first);
    int n = 0;
    first = 0;
    for (int a = 255; a >= 0; a--)
      if (got_board[a] !== exp_cell(a)) begin
        first = a;
        n++;
      end
    return n;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit u, input bit d, input bit l, input bit r, input bit rv, input bit fl);
    {btn_up, btn_down, btn_left, btn_right, btn_reveal, btn_flag} = {u, d, l, r, rv, fl};
    tick();
    {btn_up, btn_down, btn_left, btn_right, btn_reveal, btn_flag} = '0;
  endtask

  task automatic move_to(int tx, int ty);
    for (int k = 0; k < 40 && (m_x != tx || m_y != ty); k++) begin
      if (m_y > ty) begin drive(1, 0, 0, 0, 0, 0); m_move(1, 0, 0, 0); end
      else if (m_y < ty) begin drive(0, 1, 0, 0, 0, 0); m_move(0, 1, 0, 0); end
      else if (m_x > tx) begin drive(0, 0, 1, 0, 0, 0); m_move(0, 0, 1, 0); end
      else begin drive(0, 0, 0, 1, 0, 0); m_move(0, 0, 0, 1); end
    end
  endtask

  task automatic start_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    for (int i = 0; i < 256; i++) begin m_rev[i] = 1'b0; m_flag[i] = 1'b0; end
    m_x = 0; m_y = 0; m_gs = 0;
  endtask

  task automatic load_mines();
    for (int a = 0; a < 256; a++) begin
      mine_we = 1'b1; mine_waddr = 8'(a); mine_wdata = m_mine[a];
      tick();
    end
    mine_we = 1'b0;
  endtask

  task automatic read_board();
    for (int a = 0; a <= 256; a++) begin
      if (a > 0) got_board[a - 1] = rd_cell;
      if (a < 256) rd_addr = 8'(a);
      tick();
    end
  endtask

  task automatic settle(output bit ok);
    int n = 0;
    while (busy === 1'b1 && n < 256 * 80) begin n++; tick(); end
    ok = (busy !== 1'b1);
    tick();
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int nb, f;
    rst = 1'b0;
    {btn_up, btn_down, btn_left, btn_right, btn_reveal, btn_flag} = '0;
    new_game = 1'b0; mine_we = 1'b0; mine_waddr = '0; mine_wdata = 1'b0; rd_addr = 8'h55;
    for (int i = 0; i < 256; i++) begin m_mine[i] = 0; m_rev[i] = 0; m_flag[i] = 0; end
    m_x = 0; m_y = 0; m_gs = 0;
    #12;
    checks++;
    if ({x_pos, y_pos, busy, game_state, rd_cell} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs: x=%0d y=%0d busy=%b gs=%0d rd=%b, want all zero",
               x_pos, y_pos, busy, game_state, rd_cell);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    read_board();
    nb = board_bad(f);
    checks++;
    if (nb !== 0) begin
      errors++;
      $display("FAIL reset_board: %0d cells differ, first @%0d got %b want %b", nb, f, got_board[f], exp_cell(f));
    end
  endtask

  task automatic test_cursor();
    bit u, d, l, r;
    repeat (20) begin drive(0, 0, 1, 0, 0, 0); m_move(0, 0, 1, 0); end
    repeat (20) begin drive(1, 0, 0, 0, 0, 0); m_move(1, 0, 0, 0); end
    checks++;
    if (x_pos !== 4'd0 || y_pos !== 4'd0) begin
      errors++;
      $display("FAIL cursor_min: got (%0d,%0d) want (0,0)", x_pos, y_pos);
    end
    repeat (20) begin drive(0, 0, 0, 1, 0, 0); m_move(0, 0, 0, 1); end
    checks++;
    if (x_pos !== 4'd15 || y_pos !== 4'd0) begin
      errors++;
      $display("FAIL cursor_max_x: got (%0d,%0d) want (15,0)", x_pos, y_pos);
    end
    for (int k = 0; k < 40; k++) begin
      {u, d, l, r} = 4'($urandom);
      drive(u, d, l, r, 0, 0);
      m_move(u, d, l, r);
      checks++;
      if (x_pos !== 4'(m_x) || y_pos !== 4'(m_y)) begin
        errors++;
        $display("FAIL cursor_rand step %0d btn=%b%b%b%b: got (%0d,%0d) want (%0d,%0d)",
                 k, u, d, l, r, x_pos, y_pos, m_x, m_y);
      end
    end
  endtask

  task automatic test_single_adj();
    bit saw_busy = 1'b0;
    int nb, f;
    start_game();
    for (int i = 0; i < 256; i++) m_mine[i] = (i == 8'h11);
    load_mines();
    move_to(0, 0);
    drive(0, 0, 0, 0, 1, 0);
    m_reveal(0);
    for (int k = 0; k < 4; k++) begin saw_busy |= (busy === 1'b1); tick(); end
    checks++;
    if (saw_busy) begin
      errors++;
      $display("FAIL adj1_busy: busy seen 1, want never asserted");
    end
    checks++;
    if (game_state !== 2'(m_gs)) begin
      errors++;
      $display("FAIL adj1_state: got %0d want %0d", game_state, m_gs);
    end
    read_board();
    checks++;
    if (got_board[0] !== 7'b100_0001) begin
      errors++;
      $display("FAIL adj1_cell0: got %b want 1000001", got_board[0]);
    end
    nb = board_bad(f);
    checks++;
    if (nb !== 0) begin
      errors++;
      $display("FAIL adj1_board: %0d cells differ, first @%0d got %b want %b", nb, f, got_board[f], exp_cell(f));
    end
  endtask

  task automatic test_sweep_win();
    int n = 0;
    int nb, f, opened;
    start_game();
    for (int i = 0; i < 256; i++) m_mine[i] = (i == 255);
    load_mines();
    move_to(0, 0);
    drive(0, 0, 0, 0, 1, 0);
    m_reveal(0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL sweep_busy: got %b want 1", busy);
    end
    while (busy === 1'b1 && n < 256 * 16) begin n++; tick(); end
    // Mine in the last cell: one opening pass plus one clean pass.
    checks++;
    if (n == 0 || n > 256 * 2 + 1) begin
      errors++;
      $display("FAIL sweep_len: busy for %0d cycles, want 1..%0d", n, 256 * 2 + 1);
    end
    tick();
    tick();
    checks++;
    if (game_state !== 2'd2 || m_gs != 2) begin
      errors++;
      $display("FAIL sweep_won: got %0d model %0d want 2", game_state, m_gs);
    end
    read_board();
    opened = 0;
    for (int a = 0; a < 256; a++) opened += int'(got_board[a][RD_REVEALED]);
    checks++;
    if (opened != 255) begin
      errors++;
      $display("FAIL sweep_count: got %0d revealed want 255", opened);
    end
    nb = board_bad(f);
    checks++;
    if (nb !== 0) begin
      errors++;
      $display("FAIL sweep_board: %0d cells differ, first @%0d got %b want %b", nb, f, got_board[f], exp_cell(f));
    end
  endtask

  task automatic test_flag_lost();
    bit ok;
    int nb, f;
    start_game();
    for (int i = 0; i < 256; i++) m_mine[i] = ($urandom_range(0, 99) < 12);
    m_mine[8'h33] = 1'b1;
    load_mines();
    move_to(3, 3);
    drive(0, 0, 0, 0, 0, 1); m_flag_op(8'h33); settle(ok);
    drive(0, 0, 0, 0, 1, 0); m_reveal(8'h33); settle(ok);
    checks++;
    if (game_state !== 2'd0) begin
      errors++;
      $display("FAIL flagged_reveal_state: got %0d want 0", game_state);
    end
    read_board();
    nb = board_bad(f);
    checks++;
    if (nb !== 0 || got_board[8'h33][RD_FLAGGED] !== 1'b1) begin
      errors++;
      $display("FAIL flagged_reveal_board: %0d cells differ, first @%0d got %b want %b", nb, f, got_board[f], exp_cell(f));
    end
    drive(0, 0, 0, 0, 0, 1); m_flag_op(8'h33); settle(ok);
    drive(0, 0, 0, 0, 1, 0); m_reveal(8'h33); settle(ok);
    checks++;
    if (game_state !== 2'd1 || m_gs != 1) begin
      errors++;
      $display("FAIL lost_state: got %0d model %0d want 1", game_state, m_gs);
    end
    read_board();
    nb = board_bad(f);
    checks++;
    if (nb !== 0) begin
      errors++;
      $display("FAIL lost_board: %0d cells differ, first @%0d got %b want %b", nb, f, got_board[f], exp_cell(f));
    end
  endtask

  task automatic test_reveal_flag_same();
    bit ok;
    int a, nb, f;
    start_game();
    for (int i = 0; i < 256; i++) m_mine[i] = ($urandom_range(0, 99) < 15);
    load_mines();
    a = int'($urandom_range(0, 255));
    while (m_mine[a]) a = (a + 1) % 256;
    move_to(a % 16, a / 16);
    drive(0, 0, 0, 0, 1, 1);
    m_reveal(a);
    settle(ok);
    read_board();
    checks++;
    if (got_board[a][RD_REVEALED] !== 1'b1 || got_board[a][RD_FLAGGED] !== 1'b0) begin
      errors++;
      $display("FAIL reveal_flag_same @%0d: got rev=%b flag=%b want rev=1 flag=0",
               a, got_board[a][RD_REVEALED], got_board[a][RD_FLAGGED]);
    end
    nb = board_bad(f);
    checks++;
    if (!ok || nb !== 0) begin
      errors++;
      $display("FAIL reveal_flag_board: settled=%b, %0d cells differ, first @%0d got %b want %b",
               ok, nb, f, got_board[f], exp_cell(f));
    end
  endtask

  task automatic test_new_game_mid_sweep();
    int nb, f, opened;
    start_game();
    for (int i = 0; i < 256; i++) m_mine[i] = (i == 255);
    load_mines();
    move_to(5, 2);
    drive(0, 0, 0, 0, 1, 0);
    repeat (40) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midsweep_busy_before: got %b want 1", busy);
    end
    start_game();
    checks++;
    if (busy !== 1'b0 || x_pos !== 4'd0 || y_pos !== 4'd0) begin
      errors++;
      $display("FAIL midsweep_abort: busy=%b cursor=(%0d,%0d) want busy=0 (0,0)", busy, x_pos, y_pos);
    end
    read_board();
    opened = 0;
    for (int a = 0; a < 256; a++) opened += int'(got_board[a][RD_REVEALED]);
    checks++;
    if (opened != 0 || got_board[255][RD_MINE] !== 1'b1) begin
      errors++;
      $display("FAIL midsweep_board: revealed=%0d mine255=%b want revealed=0 mine255=1",
               opened, got_board[255][RD_MINE]);
    end
    nb = board_bad(f);
    checks++;
    if (nb !== 0) begin
      errors++;
      $display("FAIL midsweep_cells: %0d cells differ, first @%0d got %b want %b", nb, f, got_board[f], exp_cell(f));
    end
  endtask

  task automatic test_random_games();
    bit ok;
    int a, op, nb, f;
    for (int g = 0; g < 2; g++) begin
      start_game();
      for (int i = 0; i < 256; i++) m_mine[i] = ($urandom_range(0, 99) < 18);
      load_mines();
      for (int c = 0; c < 6 && m_gs == 0; c++) begin
        a = int'($urandom_range(0, 255));
        move_to(a % 16, a / 16);
        op = int'($urandom_range(0, 7));
        if (op < 5) begin drive(0, 0, 0, 0, 1, 0); m_reveal(a); end
        else if (op < 7) begin drive(0, 0, 0, 0, 0, 1); m_flag_op(a); end
        else begin drive(0, 0, 0, 0, 1, 1); m_reveal(a); end
        settle(ok);
        checks++;
        if (!ok || game_state !== 2'(m_gs) || x_pos !== 4'(m_x) || y_pos !== 4'(m_y)) begin
          errors++;
          $display("FAIL rand_status g%0d c%0d op%0d @%0d: settled=%b gs=%0d pos=(%0d,%0d) want gs=%0d pos=(%0d,%0d)",
                   g, c, op, a, ok, game_state, x_pos, y_pos, m_gs, m_x, m_y);
        end
        read_board();
        nb = board_bad(f);
        checks++;
        if (nb !== 0) begin
          errors++;
          $display("FAIL rand_board g%0d c%0d: %0d cells differ, first @%0d got %b want %b",
                   g, c, nb, f, got_board[f], exp_cell(f));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_cursor();
    test_single_adj();
    test_sweep_win();
    test_flag_lost();
    test_reveal_flag_same();
    test_new_game_mid_sweep();
    test_random_games();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
